// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, register map and FSM encoding for the SPI frame sequencer
package spi_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int FRAME_BITS = 16;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0 = 7'h00;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_MODE_7_0 = 7'h02;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_MODE_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY_CYCLE_7_0 = 7'h04;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop pin synchroniser with an extra delay flop for rise/fall detection
module spi_sync_edge #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  // chain[STAGES-1] is the synced value, chain[STAGES] its one-cycle-old copy
  logic [STAGES:0] chain;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chain <= {(STAGES+1){RST_VAL}};
    else chain <= {chain[STAGES-1:0], d};
  assign q = chain[STAGES-1];
  assign rise = chain[STAGES-1] & ~chain[STAGES];
  assign fall = ~chain[STAGES-1] & chain[STAGES];
endmodule

// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer: synchronises SPI pins, shifts 16-bit frames and
// commits validated {rw, addr, data} writes as single-cycle pulses.
module spi_frame_sequencer
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter logic [ADDR_W-1:0] MAX_ADDR = REG_PWM_DUTY_CYCLE_7_0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              COPI,
  input  logic              nCS,
  input  logic              SCLK,
  output logic              txn_valid,
  output logic              txn_rw,
  output logic [ADDR_W-1:0] txn_addr,
  output logic [DATA_W-1:0] txn_data,
  output logic              txn_drop,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);
  logic ncs_s, ncs_rise, ncs_fall;
  logic sclk_s, sclk_rise, sclk_fall_unused;
  logic copi_s, copi_rise_unused, copi_fall_unused;
  state_t state;
  logic [4:0] bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic overrun;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst_n(rst_n), .d(nCS), .q(ncs_s), .rise(ncs_rise), .fall(ncs_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(SCLK), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall_unused));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk(clk), .rst_n(rst_n), .d(COPI), .q(copi_s), .rise(copi_rise_unused), .fall(copi_fall_unused));

  // nCS edges are tested before SCLK edges so a coincident SCLK edge is ignored
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      overrun <= 1'b0;
      txn_valid <= 1'b0;
      txn_rw <= 1'b0;
      txn_addr <= '0;
      txn_data <= '0;
      txn_drop <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      txn_valid <= 1'b0;
      txn_drop <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (ncs_fall) begin
          state <= SHIFT;
          bit_cnt <= '0;
          shreg <= '0;
          overrun <= 1'b0;
        end
        SHIFT: if (ncs_rise) begin
          frame_err <= 1'b1;
          state <= IDLE;
        end else if (sclk_rise) begin
          shreg <= {shreg[FRAME_BITS-2:0], copi_s};
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'(FRAME_BITS - 1)) state <= DONE;
        end
        DONE: if (ncs_rise) begin
          if (overrun) frame_err <= 1'b1;
          else if (shreg[15] && shreg[14:8] <= MAX_ADDR) begin
            txn_valid <= 1'b1;
            txn_rw <= shreg[15];
            txn_addr <= shreg[14:8];
            txn_data <= shreg[7:0];
            frame_cnt <= frame_cnt + 8'd1;
          end else txn_drop <= 1'b1;
          state <= IDLE;
        end else if (sclk_rise) overrun <= 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// tb_spi_frame_sequencer: drives SPI frames and checks pulses and fields against a frame-level model
module tb_spi_frame_sequencer;
  localparam int HALF = 4;
  localparam logic [6:0] MAXA = 7'h04;
  logic clk = 1'b0, rst_n = 1'b0, COPI = 1'b0, nCS = 1'b1, SCLK = 1'b0;
  logic txn_valid, txn_rw, txn_drop, frame_err;
  logic [6:0] txn_addr;
  logic [7:0] txn_data, frame_cnt;
  int errors = 0, checks = 0;
  int n_valid = 0, n_drop = 0, n_err = 0;
  logic exp_rw = 1'b0;
  logic [6:0] exp_addr = '0;
  logic [7:0] exp_data = '0;
  int exp_cnt = 0;

  spi_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .COPI(COPI), .nCS(nCS), .SCLK(SCLK),
    .txn_valid(txn_valid), .txn_rw(txn_rw), .txn_addr(txn_addr), .txn_data(txn_data),
    .txn_drop(txn_drop), .frame_err(frame_err), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (txn_valid === 1'b1) n_valid++;
    if (txn_drop === 1'b1) n_drop++;
    if (frame_err === 1'b1) n_err++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    exp_rw = 1'b0; exp_addr = '0; exp_data = '0; exp_cnt = 0;
  endtask

  // Sends a frame of nbits SCLK pulses (bits past 16 are random), optionally with an
  // extra SCLK rise coincident with nCS rising, then checks outcome against the model.
  task automatic do_frame(input string name, input logic [15:0] v, input int nbits,
                          input bit coin, input bit held);
    int v0, d0, e0;
    bit ev, ed, ee;
    v0 = n_valid; d0 = n_drop; e0 = n_err;
    if (!held) nCS = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      COPI = (i < 16) ? v[15-i] : 1'($urandom);
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    if (coin) SCLK = 1'b1;
    nCS = 1'b1;
    repeat (HALF) @(negedge clk);
    SCLK = 1'b0;
    repeat (12) @(negedge clk);
    ee = (nbits != 16);
    ev = !ee && v[15] && (v[14:8] <= MAXA);
    ed = !ee && !ev;
    if (ev) begin
      exp_rw = v[15]; exp_addr = v[14:8]; exp_data = v[7:0]; exp_cnt = (exp_cnt + 1) % 256;
    end
    checks++;
    if ((n_valid - v0) !== int'(ev)) begin
      errors++; $display("FAIL %s valid_pulses: got %0d want %0d", name, n_valid - v0, ev);
    end
    checks++;
    if ((n_drop - d0) !== int'(ed)) begin
      errors++; $display("FAIL %s drop_pulses: got %0d want %0d", name, n_drop - d0, ed);
    end
    checks++;
    if ((n_err - e0) !== int'(ee)) begin
      errors++; $display("FAIL %s err_pulses: got %0d want %0d", name, n_err - e0, ee);
    end
    checks++;
    if ({txn_rw, txn_addr, txn_data} !== {exp_rw, exp_addr, exp_data}) begin
      errors++; $display("FAIL %s fields: got %h/%h/%h want %h/%h/%h", name,
                         txn_rw, txn_addr, txn_data, exp_rw, exp_addr, exp_data);
    end
    checks++;
    if (frame_cnt !== 8'(exp_cnt)) begin
      errors++; $display("FAIL %s frame_cnt: got %h want %h", name, frame_cnt, 8'(exp_cnt));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({txn_valid, txn_rw, txn_addr, txn_data, txn_drop, frame_err, frame_cnt} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h/%h/%h/%h/%h/%h/%h want all 0",
                         txn_valid, txn_rw, txn_addr, txn_data, txn_drop, frame_err, frame_cnt);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_directed();
    do_frame("write_80a5", 16'h80A5, 16, 0, 0);
    do_frame("read_0412", 16'h0412, 16, 0, 0);
    do_frame("addr5_8533", 16'h8533, 16, 0, 0);
    do_frame("addr4_84ff", 16'h84FF, 16, 0, 0);
  endtask

  task automatic test_bad_length();
    do_frame("short_10", 16'h8123, 10, 0, 0);
    do_frame("long_17", 16'h8123, 17, 0, 0);
    do_frame("after_err_8342", 16'h8342, 16, 0, 0);
  endtask

  task automatic test_reset_mid_frame();
    nCS = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      COPI = 1'($urandom);
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({txn_valid, txn_rw, txn_addr, txn_data, txn_drop, frame_err, frame_cnt} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got %h/%h/%h/%h/%h/%h/%h want all 0",
                         txn_valid, txn_rw, txn_addr, txn_data, txn_drop, frame_err, frame_cnt);
    end
    rst_n = 1'b1;
    model_reset();
    do_frame("midreset_8142", 16'h8142, 16, 0, 1);
    checks++;
    if (frame_cnt !== 8'h01) begin
      errors++; $display("FAIL midreset_cnt: got %h want 01", frame_cnt);
    end
  endtask

  task automatic test_coincident();
    do_frame("coincident_8207", 16'h8207, 16, 1, 0);
  endtask

  task automatic test_random();
    logic [15:0] v;
    int nb;
    for (int k = 0; k < 30; k++) begin
      v = 16'($urandom);
      if ($urandom_range(1) == 1) v[14:8] = 7'($urandom_range(6));
      case ($urandom_range(5))
        0: nb = 10;
        1: nb = 17;
        default: nb = 16;
      endcase
      do_frame("random", v, nb, 1'($urandom), 0);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] v;
    test_reset();
    for (int k = 0; k < 256; k++) begin
      v = {1'b1, 7'($urandom_range(4)), 8'($urandom)};
      do_frame("wrap", v, 16, 0, 0);
    end
    checks++;
    if (frame_cnt !== 8'h00) begin
      errors++; $display("FAIL wrap_cnt: got %h want 00", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bad_length();
    test_reset_mid_frame();
    test_coincident();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
